order_seq: RTL and testbench
============================

ORDER_SEQ -- requirements
Module: order_seq

Interface
REQ-001 SHALL have: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have: resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: start  input  1  pulse; begin one arithmetic order.
REQ-004 SHALL have: opcode  input  3  sampled with start; 0 add, 1 sub, 2 mul, 3 div, 4 and, 5-7 illegal.
REQ-005 SHALL have: abs_flag  input  1  sampled with start; operands taken as absolute values.
REQ-006 SHALL have: abort  input  1  pulse; cancel current order.
REQ-007 SHALL have: mem_rd_done / mem_wr_done  input  1 each  pulse; memory transfer complete.
REQ-008 SHALL have: ac_answer  input  1  pulse; arithmetic stage finished.
REQ-009 SHALL have: mem_rd_req / mem_wr_req  output  1 each  pulse; request memory read into C / write from C.
REQ-010 SHALL have: operand_sel  output  2  level; 0 first operand, 1 second operand, 2 result address.
REQ-011 SHALL have: clear_a, move_c_to_a, move_c_to_b  output  1 each  pulse, to arithmetic stage.
REQ-012 SHALL have: order_add, order_sub, order_mul, order_div, order_and  output  1 each  pulse, one-hot.
REQ-013 SHALL have: ctrl_abs  output  1  level; latched abs_flag, held for the whole order.
REQ-014 SHALL have: busy  output  1  level; high in every state except IDLE.
REQ-015 SHALL have: done, err  output  1 each  pulse; order completed / order failed.
REQ-016 SHALL have: fault  output  1  level; sticky, set with err, cleared only by a start that is accepted.

Function
REQ-017 SHALL implement states IDLE, CLR, RD1, W1, LDA, RD2, W2, LDB, ORD, WAIT, WR, WW, FIN, ERR, one-hot encoded.
REQ-018 SHALL, in IDLE with start and legal opcode, latch opcode and abs_flag, clear fault, go to CLR.
REQ-019 SHALL, in IDLE with start and illegal opcode, go to ERR; no other pulse issued.
REQ-020 SHALL ignore start when busy is high.
REQ-021 SHALL pulse, one cycle each: CLR clear_a; RD1 mem_rd_req (sel 0); LDA move_c_to_a; RD2 mem_rd_req (sel 1); LDB move_c_to_b; ORD the latched order_*; WR mem_wr_req (sel 2); FIN done; ERR err.
REQ-022 SHALL advance CLR->RD1->W1, LDA->RD2->W2, LDB->ORD->WAIT, WR->WW unconditionally, one cycle per state.
REQ-023 SHALL leave W1, W2 and WW on the respective done pulse (W1->LDA, W2->LDB, WW->FIN); FIN->IDLE and ERR->IDLE unconditionally.
REQ-024 SHALL, in WAIT, count cycles with a 7-bit watchdog reset on ORD entry; ac_answer -> WR; count reaching 100 without answer -> ERR (divide overflow case).
REQ-025 SHALL give ac_answer priority over timeout in the same cycle.
REQ-026 SHALL ignore mem_*_done and ac_answer outside their wait states.
REQ-027 SHALL, on abort in any non-IDLE state, go to IDLE next cycle, no done/err, fault unchanged; abort wins over every concurrent event.
REQ-028 SHALL hold operand_sel at the value of the last request state until the next request state.

Reset
REQ-029 SHALL, while resetn low, force IDLE, watchdog 0, latched opcode 0, ctrl_abs 0, fault 0, operand_sel 0, all pulse outputs 0, busy 0.
REQ-030 SHALL treat reset mid-order identically to reset from IDLE; no pulse emitted during or on exit from reset.

Structure
REQ-031 SHALL take opcode encodings, watchdog limit (100) and operand_sel codes from the shared constants header.
REQ-032 SHALL place the watchdog in sub-module order_watchdog (inputs clear, enable; output expired).
REQ-033 SHALL be single clock domain, no latches, all outputs registered or decoded from one-hot state only.

Verification
REQ-034 Add: start opcode 0 at cycle 0, rd_done returned 2 cycles after each request, answer 3 cycles after order -> clear_a c1, rd_req c2/c6, move_c_to_a c5, move_c_to_b c9, order_add c10, wr_req c14, done c17 with wr_done at c16.
REQ-035 Div timeout: opcode 3, never assert ac_answer -> err exactly 100 cycles after WAIT entry, fault high, busy low next cycle.
REQ-036 Illegal opcode 6 -> err one cycle after start, no clear_a, no mem_rd_req; next legal start clears fault.
REQ-037 Abort in W2 -> busy low next cycle, no move_c_to_b, no done; late mem_rd_done ignored.
REQ-038 start asserted in WAIT -> ignored, opcode latch unchanged; ac_answer and timeout same cycle -> WR, no err.
REQ-039 resetn low during WAIT of mul -> all outputs 0 next cycle; fresh start afterward completes normally.

Source files
------------

// File: rtl/order_seq_pkg.sv
// Shared constants for the order sequencer: opcode encodings, watchdog limit,
// operand select codes and the one-hot state encoding.
package order_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;

    localparam int              WD_W     = 7;
    localparam logic [WD_W-1:0] WD_LIMIT = 7'd100;

    localparam logic [1:0] SEL_OP1 = 2'd0;
    localparam logic [1:0] SEL_OP2 = 2'd1;
    localparam logic [1:0] SEL_RES = 2'd2;

    typedef enum logic [13:0] {
        S_IDLE = 14'h0001,
        S_CLR  = 14'h0002,
        S_RD1  = 14'h0004,
        S_W1   = 14'h0008,
        S_LDA  = 14'h0010,
        S_RD2  = 14'h0020,
        S_W2   = 14'h0040,
        S_LDB  = 14'h0080,
        S_ORD  = 14'h0100,
        S_WAIT = 14'h0200,
        S_WR   = 14'h0400,
        S_WW   = 14'h0800,
        S_FIN  = 14'h1000,
        S_ERR  = 14'h2000
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_AND);
    endfunction

endpackage

// File: rtl/order_seq_watchdog.sv
// Cycle watchdog for the arithmetic wait: cleared on demand, counts while
// enabled, and flags expiry on the cycle the count reaches the limit.
module order_watchdog
    import order_seq_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WD_W-1:0] count_q;
    logic [WD_W-1:0] count_d;

    // Expiry is seen during the 100th enabled cycle so the owner can leave then.
    assign expired = enable && (count_q == (WD_LIMIT - 7'd1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/order_seq.sv
// Sequencer for one arithmetic order: fetch two operands into the arithmetic
// stage, issue the order, wait for the answer and write the result back.
module order_seq
    import order_seq_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       abs_flag,
    input  logic       abort,
    input  logic       mem_rd_done,
    input  logic       mem_wr_done,
    input  logic       ac_answer,
    output logic       mem_rd_req,
    output logic       mem_wr_req,
    output logic [1:0] operand_sel,
    output logic       clear_a,
    output logic       move_c_to_a,
    output logic       move_c_to_b,
    output logic       order_add,
    output logic       order_sub,
    output logic       order_mul,
    output logic       order_div,
    output logic       order_and,
    output logic       ctrl_abs,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       fault,
    output state_e     dbg_state
);

    state_e     state_q, state_d;
    logic [2:0] opcode_q, opcode_d;
    logic       abs_q, abs_d;
    logic       fault_q, fault_d;
    logic [1:0] sel_q, sel_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    order_watchdog u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        abs_d     = abs_q;
        fault_d   = fault_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_legal(opcode)) begin
                        opcode_d = opcode;
                        abs_d    = abs_flag;
                        fault_d  = 1'b0;
                        state_d  = S_CLR;
                    end else begin
                        state_d  = S_ERR;
                    end
                end
            end
            S_CLR:  state_d = S_RD1;
            S_RD1:  state_d = S_W1;
            S_W1:   if (mem_rd_done) state_d = S_LDA;
            S_LDA:  state_d = S_RD2;
            S_RD2:  state_d = S_W2;
            S_W2:   if (mem_rd_done) state_d = S_LDB;
            S_LDB:  state_d = S_ORD;
            S_ORD: begin
                wd_clear = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                wd_enable = 1'b1;
                // An answer arriving on the expiry cycle still counts as success.
                if (ac_answer) begin
                    state_d = S_WR;
                end else if (wd_expired) begin
                    state_d = S_ERR;
                end
            end
            S_WR:   state_d = S_WW;
            S_WW:   if (mem_wr_done) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        if ((state_d == S_ERR) && (state_q != S_ERR)) begin
            fault_d = 1'b1;
        end
    end

    // operand_sel follows the request state being entered and holds until the next one.
    always_comb begin
        sel_d = sel_q;
        case (state_d)
            S_RD1:   sel_d = SEL_OP1;
            S_RD2:   sel_d = SEL_OP2;
            S_WR:    sel_d = SEL_RES;
            default: sel_d = sel_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            opcode_q <= 3'd0;
            abs_q    <= 1'b0;
            fault_q  <= 1'b0;
            sel_q    <= SEL_OP1;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            abs_q    <= abs_d;
            fault_q  <= fault_d;
            sel_q    <= sel_d;
        end
    end

    assign clear_a     = (state_q == S_CLR);
    assign mem_rd_req  = (state_q == S_RD1) || (state_q == S_RD2);
    assign move_c_to_a = (state_q == S_LDA);
    assign move_c_to_b = (state_q == S_LDB);
    assign mem_wr_req  = (state_q == S_WR);
    assign done        = (state_q == S_FIN);
    assign err         = (state_q == S_ERR);
    assign busy        = (state_q != S_IDLE);

    assign order_add = (state_q == S_ORD) && (opcode_q == OP_ADD);
    assign order_sub = (state_q == S_ORD) && (opcode_q == OP_SUB);
    assign order_mul = (state_q == S_ORD) && (opcode_q == OP_MUL);
    assign order_div = (state_q == S_ORD) && (opcode_q == OP_DIV);
    assign order_and = (state_q == S_ORD) && (opcode_q == OP_AND);

    assign operand_sel = sel_q;
    assign ctrl_abs    = abs_q;
    assign fault       = fault_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_order_seq.sv
// Randomised bench for order_seq: a driver answers memory and arithmetic
// requests, a model queues the expected pulse events, a monitor checks them.
module tb_order_seq;
    import order_seq_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       abs_flag = 1'b0;
    logic       abort = 1'b0;
    logic       mem_rd_done = 1'b0;
    logic       mem_wr_done = 1'b0;
    logic       ac_answer = 1'b0;
    logic       mem_rd_req, mem_wr_req;
    logic [1:0] operand_sel;
    logic       clear_a, move_c_to_a, move_c_to_b;
    logic       order_add, order_sub, order_mul, order_div, order_and;
    logic       ctrl_abs, busy, done, err, fault;
    state_e     dbg_state;

    order_seq dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .opcode      (opcode),
        .abs_flag    (abs_flag),
        .abort       (abort),
        .mem_rd_done (mem_rd_done),
        .mem_wr_done (mem_wr_done),
        .ac_answer   (ac_answer),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .operand_sel (operand_sel),
        .clear_a     (clear_a),
        .move_c_to_a (move_c_to_a),
        .move_c_to_b (move_c_to_b),
        .order_add   (order_add),
        .order_sub   (order_sub),
        .order_mul   (order_mul),
        .order_div   (order_div),
        .order_and   (order_and),
        .ctrl_abs    (ctrl_abs),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .fault       (fault),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] exp_q[$];
    int          stamp_q[$];

    // Model of the externally visible registers.
    logic [1:0] m_sel = 2'd0;
    logic       m_abs = 1'b0;
    logic       m_fault = 1'b0;

    localparam int OUT_OK      = 0;
    localparam int OUT_TIMEOUT = 1;
    localparam int OUT_CUT_RD2 = 2;
    localparam int OUT_CUT_ORD = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ctl = {clear_a, move_a, move_b, rd_req, wr_req, done, err}
    task automatic push_ev(input logic [4:0] ord, input logic [6:0] ctl);
        exp_q.push_back({ord, ctl, m_sel, m_abs, m_fault});
    endtask

    // Expected pulse sequence of one order, straight from the described flow.
    task automatic model_order(input logic [2:0] op, input logic ab, input int outcome);
        logic [4:0] ord;
        if (op > 3'd4) begin
            m_fault = 1'b1;
            push_ev(5'd0, 7'b0000001);
            return;
        end
        m_abs   = ab;
        m_fault = 1'b0;
        push_ev(5'd0, 7'b1000000);
        m_sel = 2'd0;
        push_ev(5'd0, 7'b0001000);
        push_ev(5'd0, 7'b0100000);
        m_sel = 2'd1;
        push_ev(5'd0, 7'b0001000);
        if (outcome == OUT_CUT_RD2) return;
        push_ev(5'd0, 7'b0010000);
        ord = 5'd1 << op;
        push_ev(ord, 7'b0000000);
        if (outcome == OUT_CUT_ORD) return;
        if (outcome == OUT_TIMEOUT) begin
            m_fault = 1'b1;
            push_ev(5'd0, 7'b0000001);
            return;
        end
        m_sel = 2'd2;
        push_ev(5'd0, 7'b0000100);
        push_ev(5'd0, 7'b0000010);
    endtask

    // ---------------- monitor ----------------
    logic [15:0] act_w, exp_w;
    always @(negedge clk) begin
        act_w = {order_and, order_div, order_mul, order_sub, order_add,
                 clear_a, move_c_to_a, move_c_to_b, mem_rd_req, mem_wr_req, done, err,
                 operand_sel, ctrl_abs, fault};
        if (|act_w[15:4]) begin
            stamp_q.push_back(cyc);
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL event_unexpected: got %h at cycle %0d, expected none", act_w, cyc);
            end else begin
                exp_w = exp_q.pop_front();
                if (act_w !== exp_w) begin
                    tests_failed++;
                    $display("FAIL event: got %h at cycle %0d, expected %h", act_w, cyc, exp_w);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // which: 0 rd_req, 1 wr_req, 2 any order pulse, 3 err, 4 idle
    task automatic wait_for(input int which, input int bound, input string name, output int at);
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        at  = -1;
        while (!hit && n < bound) begin
            case (which)
                0:       hit = mem_rd_req;
                1:       hit = mem_wr_req;
                2:       hit = |{order_add, order_sub, order_mul, order_div, order_and};
                3:       hit = err;
                default: hit = !busy;
            endcase
            if (hit) at = cyc;
            else begin
                @(negedge clk);
                n++;
            end
        end
        tests_run++;
        if (!hit) begin
            tests_failed++;
            $display("FAIL %s_wait: no event within %0d cycles, required one", name, bound);
        end
    endtask

    // which: 0 rd_done, 1 wr_done, 2 ac_answer, 3 abort
    task automatic pulse_in(input int which);
        case (which)
            0:       mem_rd_done = 1'b1;
            1:       mem_wr_done = 1'b1;
            2:       ac_answer   = 1'b1;
            default: abort       = 1'b1;
        endcase
        @(negedge clk);
        mem_rd_done = 1'b0;
        mem_wr_done = 1'b0;
        ac_answer   = 1'b0;
        abort       = 1'b0;
    endtask

    // mode: 0 normal, 1 abort in W2, 2 reset in WAIT, 3 stray start in WAIT
    // ans_lat: cycles from order pulse to answer; 0 means never answered.
    task automatic run_order(input logic [2:0] op, input logic ab, input int mem_lat,
                             input int ans_lat, input int mode, output int s);
        int  r, o, e, t, outcome;
        bit  timeout;
        logic [31:0] outs;
        timeout = (ans_lat == 0) || (ans_lat > 100);
        if (mode == 1)      outcome = OUT_CUT_RD2;
        else if (mode == 2) outcome = OUT_CUT_ORD;
        else if (timeout)   outcome = OUT_TIMEOUT;
        else                outcome = OUT_OK;
        model_order(op, ab, outcome);

        @(negedge clk);
        s        = cyc;
        start    = 1'b1;
        opcode   = op;
        abs_flag = ab;
        @(negedge clk);
        start    = 1'b0;
        opcode   = 3'($urandom_range(0, 7));
        abs_flag = 1'($urandom_range(0, 1));

        if (op > 3'd4) begin
            check("illegal_err", err, 1);
            check("illegal_no_clear", clear_a, 0);
            check("illegal_fault", fault, 1);
            @(negedge clk);
            check("illegal_busy_after", busy, 0);
            return;
        end

        wait_for(0, 10, "rd1", r);
        repeat (mem_lat) @(negedge clk);
        pulse_in(0);
        wait_for(0, 10, "rd2", r);
        if (mode == 1) begin
            @(negedge clk);
            pulse_in(3);
            check("abort_busy", busy, 0);
            pulse_in(0);
            check("abort_busy_late", busy, 0);
            @(negedge clk);
            check("abort_fault", fault, m_fault);
            return;
        end
        repeat (mem_lat) @(negedge clk);
        pulse_in(0);
        wait_for(2, 10, "order", o);

        if (mode == 2) begin
            repeat (3) @(negedge clk);
            resetn = 1'b0;
            repeat (2) begin
                @(negedge clk);
                outs = {15'd0, mem_rd_req, mem_wr_req, operand_sel, clear_a, move_c_to_a,
                        move_c_to_b, order_add, order_sub, order_mul, order_div, order_and,
                        ctrl_abs, busy, done, err, fault};
                check("reset_wait_outputs", outs, 0);
            end
            resetn  = 1'b1;
            m_sel   = 2'd0;
            m_abs   = 1'b0;
            m_fault = 1'b0;
            @(negedge clk);
            check("reset_exit_busy", busy, 0);
            return;
        end

        if (timeout) begin
            wait_for(3, 120, "timeout_err", e);
            check("timeout_err_cycle", e - o, 101);
            check("timeout_fault", fault, 1);
            if (ans_lat != 0) pulse_in(2);
            else @(negedge clk);
            check("timeout_busy_after", busy, 0);
            return;
        end

        for (int k = 0; k < ans_lat; k++) begin
            @(negedge clk);
            start = (mode == 3) && (k == 3);
            if (start) begin
                opcode   = 3'd0;
                abs_flag = !ab;
            end
        end
        start = 1'b0;
        pulse_in(2);
        wait_for(1, 10, "wr", t);
        repeat (mem_lat) @(negedge clk);
        pulse_in(1);
        wait_for(4, 10, "idle", e);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s;
        int exp_t[8];
        logic [31:0] outs;
        logic [2:0]  op;
        int          pick, ans;

        repeat (3) @(negedge clk);
        outs = {15'd0, mem_rd_req, mem_wr_req, operand_sel, clear_a, move_c_to_a,
                move_c_to_b, order_add, order_sub, order_mul, order_div, order_and,
                ctrl_abs, busy, done, err, fault};
        check("reset_outputs", outs, 0);
        check("reset_state", dbg_state, S_IDLE);
        resetn = 1'b1;
        @(negedge clk);

        // Reference add timeline with two-cycle memory and three-cycle answer.
        stamp_q.delete();
        run_order(3'd0, 1'b0, 2, 3, 0, s);
        exp_t = '{1, 2, 5, 6, 9, 10, 14, 17};
        check("add_event_count", stamp_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < stamp_q.size()) check("add_event_cycle", stamp_q[i] - s, exp_t[i]);
        end

        run_order(3'd3, 1'b1, 1, 0, 0, s);      // divide never answered
        run_order(3'd6, 1'b0, 1, 3, 0, s);      // illegal opcode
        run_order(3'd4, 1'b0, 1, 2, 0, s);      // legal start clears fault
        run_order(3'd1, 1'b1, 2, 3, 1, s);      // abort in W2
        run_order(3'd2, 1'b1, 2, 100, 3, s);    // stray start, answer on expiry cycle
        run_order(3'd2, 1'b1, 1, 5, 2, s);      // reset while waiting
        run_order(3'd2, 1'b0, 1, 4, 0, s);      // fresh order after reset

        for (int n = 0; n < 25; n++) begin
            op   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            pick = $urandom_range(0, 11);
            if (pick < 8)       ans = $urandom_range(1, 8);
            else if (pick == 8) ans = 99;
            else if (pick == 9) ans = 100;
            else if (pick == 10) ans = 101;
            else                ans = 0;
            run_order(op, 1'($urandom_range(0, 1)), $urandom_range(1, 4), ans, 0, s);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
